// File: rtl/al2_line_encoder.sv
// al2_line_encoder: packs the one-hot D/C field selects and the raw control
// sideband into the 16-bit al2 word. Each encoded word and its error flag go
// into a 2-entry in-order output FIFO. Words flagged as illegal are counted
// in a saturating 8-bit counter.
module al2_line_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] hot_d,
  input  logic [15:0] hot_c,
  input  logic [6:0]  ctl,
  input  logic        ctl_v4,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_word,
  output logic        out_err,
  output logic [7:0]  err_cnt,
  input  logic        err_clr
);

  // Lowest-set-bit isolation: a line is chosen only when every line below it is idle.
  logic [15:0] low_d;
  logic [15:0] low_c;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_low
      if (gi == 0) begin : g_first
        assign low_d[gi] = hot_d[gi];
        assign low_c[gi] = hot_c[gi];
      end else begin : g_rest
        assign low_d[gi] = hot_d[gi] & ~(|hot_d[gi-1:0]);
        assign low_c[gi] = hot_c[gi] & ~(|hot_c[gi-1:0]);
      end
    end
  endgenerate

  logic [3:0] k_idx;
  logic [3:0] j_idx;

  // Convert the isolated one-hot selects to binary indices (zero when nothing is selected).
  always_comb begin
    k_idx = 4'd0;
    j_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (low_d[i]) k_idx = k_idx | i[3:0];
      if (low_c[i]) j_idx = j_idx | i[3:0];
    end
  end

  logic        c_nz;
  logic        d_zero;
  logic        d_multi;
  logic        c_multi;
  logic        enc_err;
  logic [15:0] enc_word;

  assign c_nz    = |hot_c;
  assign d_zero  = ~(|hot_d);
  assign d_multi = |(hot_d & (hot_d - 16'd1));
  assign c_multi = |(hot_c & (hot_c - 16'd1));
  assign enc_err = d_zero | d_multi | c_multi;

  // Index bits are bit-reversed into their fields. A live C select forces v4 so the
  // decoder's C lines are enabled. Otherwise v4 is taken from the sideband.
  assign enc_word = {k_idx[0], k_idx[1], k_idx[2], k_idx[3],
                     j_idx[0], j_idx[1], j_idx[2], j_idx[3],
                     ctl[6], ctl[5], ctl[4],
                     c_nz ? 1'b1 : ctl_v4,
                     ctl[3:0]};

  // Output FIFO: two entries, in order, with explicit occupancy.
  logic [16:0] entry_reg [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  count_reg;
  logic [1:0]  count_next;
  logic        push;
  logic        pop;
  logic [16:0] head;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = entry_reg[rd_ptr_reg];
  assign out_word  = head[15:0];
  assign out_err   = head[16];

  // A simultaneous push and pop leaves occupancy unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Storage and pointer update. Reset discards all entries and zeroes the head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) entry_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        entry_reg[wr_ptr_reg] <= {enc_err, enc_word};
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  logic [7:0] err_cnt_reg;
  logic [7:0] err_cnt_next;
  logic       err_acc;

  assign err_acc = push & enc_err;
  assign err_cnt = err_cnt_reg;

  // A clear takes priority. An error word accepted in the same cycle still counts as one.
  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_clr)
      err_cnt_next = err_acc ? 8'd1 : 8'd0;
    else if (err_acc && err_cnt_reg != 8'hFF)
      err_cnt_next = err_cnt_reg + 8'd1;
  end

  // Saturating error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_reg <= 8'd0;
    else        err_cnt_reg <= err_cnt_next;
  end

endmodule

// File: tb/tb_al2_line_encoder.sv
// Bench for al2_line_encoder: directed steps from the test plan followed by
// randomized traffic, checked against a queue-based reference model.
module tb_al2_line_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] hot_d;
  logic [15:0] hot_c;
  logic [6:0]  ctl;
  logic        ctl_v4;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic        out_err;
  logic [7:0]  err_cnt;
  logic        err_clr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the expected FIFO contents {err, word} and the expected counter value.
  logic [16:0] q[$];
  int          m_cnt = 0;

  al2_line_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .hot_d     (hot_d),
    .hot_c     (hot_c),
    .ctl       (ctl),
    .ctl_v4    (ctl_v4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rev4(input int x);
    return ((x & 1) << 3) | ((x & 2) << 1) | ((x & 4) >> 1) | ((x & 8) >> 3);
  endfunction

  // Builds the expected word by adding each field's value at its bit position.
  function automatic logic [16:0] ref_encode(input logic [15:0] hd, input logic [15:0] hc,
                                             input logic [6:0] c, input logic v4);
    int k, j, nd, nc, w;
    logic err;
    k = 0;
    j = 0;
    for (int i = 15; i >= 0; i--) begin
      if (hd[i]) k = i;
      if (hc[i]) j = i;
    end
    nd  = $countones(hd);
    nc  = $countones(hc);
    err = (nd != 1) || (nc > 1);
    w = int'(c[3:0]) + int'(c[6:4]) * 32;
    w = w + ((nc > 0) ? 1 : int'(v4)) * 16;
    w = w + rev4(j) * 256 + rev4(k) * 4096;
    return {err, w[15:0]};
  endfunction

  // One clock cycle. Call it at a falling edge. It drives the inputs, checks the
  // registered outputs against the model, advances the model over the rising
  // edge, and checks err_cnt at the next falling edge.
  task automatic step(input logic v, input logic [15:0] hd, input logic [15:0] hc,
                      input logic [6:0] c, input logic c4, input logic ordy, input logic clr);
    logic [16:0] e;
    logic acc, pp;
    in_valid  = v;
    hot_d     = hd;
    hot_c     = hc;
    ctl       = c;
    ctl_v4    = c4;
    out_ready = ordy;
    err_clr   = clr;
    #1;
    check("in_ready", in_ready, (q.size() < 2));
    check("out_valid", out_valid, (q.size() > 0));
    if (q.size() > 0) begin
      check("out_word", out_word, q[0][15:0]);
      check("out_err", out_err, q[0][16]);
    end
    acc = v && (q.size() < 2);
    pp  = ordy && (q.size() > 0);
    e   = ref_encode(hd, hc, c, c4);
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (acc) q.push_back(e);
    if (clr) m_cnt = (acc && e[16]) ? 1 : 0;
    else if (acc && e[16] && m_cnt < 255) m_cnt++;
    @(negedge clk);
    check("err_cnt", err_cnt, m_cnt);
    $display("step v=%0b hd=%04h hc=%04h ctl=%02h v4=%0b ordy=%0b clr=%0b acc=%0b pop=%0b exp=%05h cnt=%0d",
             v, hd, hc, c, c4, ordy, clr, acc, pp, e, err_cnt);
  endtask

  initial begin
    logic [15:0] rd, rc;
    int r;
    rst_n = 1'b0; in_valid = 0; hot_d = 0; hot_c = 0; ctl = 0; ctl_v4 = 0;
    out_ready = 0; err_clr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_cnt", err_cnt, 0);
    @(negedge clk);

    // Single legal word with everything else zero.
    step(1, 16'h0001, 16'h0000, 7'h00, 0, 0, 0);
    check("tp1_valid", out_valid, 1);
    check("tp1_word", out_word, 16'h0000);
    check("tp1_err", out_err, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // k = 15, j = 4, all control bits set.
    step(1, 16'h8000, 16'h0010, 7'h7F, 0, 0, 0);
    check("tp2_word", out_word, 16'hF2FF);
    check("tp2_err", out_err, 0);
    check("tp2_cnt", err_cnt, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // A zero-hot D select, then a multi-hot D select.
    step(1, 16'h0000, 16'h0000, 7'h00, 0, 1, 0);
    check("tp3_err0", out_err, 1);
    step(1, 16'h0006, 16'h0000, 7'h00, 0, 1, 0);
    check("tp3_word1", out_word, 16'h8000);
    check("tp3_err1", out_err, 1);
    check("tp3_cnt", err_cnt, 2);
    step(0, 0, 0, 0, 0, 1, 0);

    // Backpressure: a third offer waits until the first pop has freed a slot.
    step(1, 16'h0002, 16'h0000, 7'h01, 1, 0, 0);
    step(1, 16'h0004, 16'h0100, 7'h02, 0, 0, 0);
    check("tp4_full", in_ready, 0);
    step(1, 16'h0008, 16'h0000, 7'h03, 1, 0, 0);
    step(1, 16'h0008, 16'h0000, 7'h03, 1, 1, 0);
    check("tp4_ready_after_pop", in_ready, 1);
    step(1, 16'h0008, 16'h0000, 7'h03, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Counter: clear alone, saturate, then a clear together with an error word.
    step(0, 0, 0, 0, 0, 1, 1);
    check("tp5_clr", err_cnt, 0);
    for (int i = 0; i < 256; i++) step(1, 16'h0000, 16'h0000, 7'h00, 0, 1, 0);
    check("tp5_sat", err_cnt, 255);
    step(1, 16'h0000, 16'h0000, 7'h00, 0, 1, 1);
    check("tp5_clr_err", err_cnt, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      rd = (r == 0) ? 16'h0 : (r == 1) ? 16'($urandom) : (16'h1 << $urandom_range(0, 15));
      r = $urandom_range(0, 9);
      rc = (r < 4) ? 16'h0 : (r == 4) ? 16'($urandom) : (16'h1 << $urandom_range(0, 15));
      step(1'($urandom_range(0, 3) != 0), rd, rc, 7'($urandom), 1'($urandom),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset with two entries queued.
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, 16'h0000, 16'h0000, 7'h00, 0, 0, 0);
    step(1, 16'h0010, 16'h0001, 7'h55, 0, 0, 0);
    check("tp6_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    q.delete();
    m_cnt = 0;
    check("tp6_out_valid", out_valid, 0);
    check("tp6_in_ready", in_ready, 1);
    check("tp6_err_cnt", err_cnt, 0);
    check("tp6_out_word", out_word, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 16'h0020, 16'h0000, 7'h2A, 1, 0, 0);
    check("tp6_after_valid", out_valid, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
